// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package rca_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca8.sv
// Existing 8-bit ripple-carry adder datapath: {cout,sum} = a + b + cin.
module rca8
  import rca_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign sum     = total_s[BYTE_W-1:0];
  assign cout    = total_s[BYTE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Time-multiplexes one 8-bit adder over NBYTES operand bytes, LSB first,
// carrying between bytes in carry_r; valid/ready on both sides.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_e          state_r;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    res_r;
  logic            carry_r;
  logic [IDXW-1:0] idx_r;

  logic [BYTE_W-1:0] add_sum_s;
  logic              add_cout_s;
  logic [W-1:0]      res_next_s;

  rca8 u_rca8 (
    .a    (a_sh_r[BYTE_W-1:0]),
    .b    (b_sh_r[BYTE_W-1:0]),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // New byte enters at the MSB end so the LSB byte lands at bit 0 after NBYTES shifts;
  // written as shift/or so NBYTES=1 needs no empty slice.
  assign res_next_s = (res_r >> BYTE_W) | (W'(add_sum_s) << (W - BYTE_W));

  // FSM, operand shift registers, result register, carry and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= {W{1'b0}};
      b_sh_r  <= {W{1'b0}};
      res_r   <= {W{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            idx_r   <= {IDXW{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> BYTE_W;
          b_sh_r  <= b_sh_r >> BYTE_W;
          res_r   <= res_next_s;
          carry_r <= add_cout_s;
          // Counter parks on the last index rather than wrapping.
          if (idx_r == LAST_IDX) begin
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign sum       = res_r;
  assign cout      = carry_r;

endmodule
